// File: rtl/move_gate.sv
// Move legality gate: registers per-direction legality from per-cell enable
// grids and arbitrates one move request at a time, with a lockout after each grant.
module move_gate #(
    parameter int ROWS        = 4,
    parameter int COLS        = 6,
    parameter int LOCK_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] up_en_i,
    input  logic [ROWS*COLS-1:0] down_en_i,
    input  logic [ROWS*COLS-1:0] left_en_i,
    input  logic [ROWS*COLS-1:0] right_en_i,
    input  logic                 mode_any_i,
    input  logic                 req_valid_i,
    input  logic [1:0]           req_dir_i,
    output logic                 req_ready_o,
    output logic                 up_en_o,
    output logic                 down_en_o,
    output logic                 left_en_o,
    output logic                 right_en_o,
    output logic                 grant_o,
    output logic                 deny_o,
    output logic [1:0]           grant_dir_o,
    output logic                 busy_o,
    input  logic                 clear_count_i,
    output logic [CNT_W-1:0]     move_count_o,
    output logic [2:0]           state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_GRANT = 3'd2,
        S_DENY  = 3'd3,
        S_LOCK  = 3'd4
    } state_t;

    localparam logic [7:0]       LOCK_LOAD = 8'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       en_q, en_d;          // {right, left, down, up}
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       gdir_q, gdir_d;
    logic [7:0]       lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_en;
    logic             accept;

    // Handshake: a request transfers on the edge where req_valid_i and
    // req_ready_o are both 1; ready is only offered in IDLE while out of reset.
    assign accept = req_valid_i && req_ready_o;

    always_comb begin
        sel_en = 1'b0;
        case (dir_q)
            2'd0:    sel_en = en_q[0];
            2'd1:    sel_en = en_q[1];
            2'd2:    sel_en = en_q[2];
            default: sel_en = en_q[3];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CHECK;
            S_CHECK: state_d = sel_en ? S_GRANT : S_DENY;
            S_GRANT: state_d = S_LOCK;
            S_DENY:  state_d = S_IDLE;
            S_LOCK:  if (lock_q <= 8'd1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; gated by rst_n so nothing pulses while reset is held
    always_comb begin
        req_ready_o = 1'b0;
        busy_o      = 1'b0;
        grant_o     = 1'b0;
        deny_o      = 1'b0;
        if (rst_n) begin
            req_ready_o = (state_q == S_IDLE);
            busy_o      = (state_q != S_IDLE);
            grant_o     = (state_q == S_GRANT);
            deny_o      = (state_q == S_DENY);
        end
    end

    // Datapath next-state
    always_comb begin
        en_d[0] = mode_any_i ? |up_en_i    : &up_en_i;
        en_d[1] = mode_any_i ? |down_en_i  : &down_en_i;
        en_d[2] = mode_any_i ? |left_en_i  : &left_en_i;
        en_d[3] = mode_any_i ? |right_en_i : &right_en_i;

        dir_d  = (state_q == S_IDLE && accept) ? req_dir_i : dir_q;
        gdir_d = (state_q == S_CHECK) ? dir_q : gdir_q;

        lock_d = lock_q;
        if (state_q == S_GRANT) begin
            lock_d = LOCK_LOAD;
        end else if (state_q == S_LOCK && lock_q != 8'd0) begin
            lock_d = lock_q - 8'd1;
        end

        cnt_d = cnt_q;
        if (clear_count_i) begin
            cnt_d = '0;
        end else if (grant_o) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q   <= '0;
            dir_q  <= '0;
            gdir_q <= '0;
            lock_q <= '0;
            cnt_q  <= '0;
        end else begin
            en_q   <= en_d;
            dir_q  <= dir_d;
            gdir_q <= gdir_d;
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end

    assign up_en_o      = en_q[0];
    assign down_en_o    = en_q[1];
    assign left_en_o    = en_q[2];
    assign right_en_o   = en_q[3];
    assign grant_dir_o  = gdir_q;
    assign move_count_o = cnt_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_move_gate.sv
// Randomized scoreboard bench for move_gate: the driver pushes expected
// grant/deny outcomes, an independent monitor pops them when a pulse appears.
module tb_move_gate;

  localparam int ROWS  = 2;
  localparam int COLS  = 3;
  localparam int N     = ROWS * COLS;
  localparam int LOCK  = 6;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]     up_en_i, down_en_i, left_en_i, right_en_i;
  logic             mode_any_i, req_valid_i, clear_count_i;
  logic [1:0]       req_dir_i;
  logic             req_ready_o, up_en_o, down_en_o, left_en_o, right_en_o;
  logic             grant_o, deny_o, busy_o;
  logic [1:0]       grant_dir_o;
  logic [CNT_W-1:0] move_count_o;
  logic [2:0]       state_dbg_o;

  move_gate #(
    .ROWS(ROWS), .COLS(COLS), .LOCK_CYCLES(LOCK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_en_i(up_en_i), .down_en_i(down_en_i),
    .left_en_i(left_en_i), .right_en_i(right_en_i),
    .mode_any_i(mode_any_i), .req_valid_i(req_valid_i), .req_dir_i(req_dir_i),
    .req_ready_o(req_ready_o),
    .up_en_o(up_en_o), .down_en_o(down_en_o),
    .left_en_o(left_en_o), .right_en_o(right_en_o),
    .grant_o(grant_o), .deny_o(deny_o), .grant_dir_o(grant_dir_o),
    .busy_o(busy_o), .clear_count_i(clear_count_i),
    .move_count_o(move_count_o), .state_dbg_o(state_dbg_o)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        gnt;
    logic [1:0]  dir;
    logic [31:0] cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  bit               rand_clr = 1'b0;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference legality: all cells enabled (mode 0) or at least one (mode 1)
  function automatic logic legal_of(input logic [N-1:0] v, input logic any);
    int ones;
    ones = $countones(v);
    return any ? (ones > 0) : (ones == N);
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    case ($urandom_range(0, 3))
      0: v = '1;
      1: v = '0;
      2: begin v = '1; v[$urandom_range(0, N-1)] = 1'b0; end
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    bit   g;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      g = 1'b0;
      if (rst_n) begin
        chk("move_count", 32'(move_count_o), 32'(exp_cnt));
        if (grant_o || deny_o) begin
          chk("single_pulse", 32'(grant_o && deny_o), 32'd0);
          chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pulse_is_grant", 32'(grant_o), 32'(e.gnt));
            chk("pulse_cycle", 32'(cyc), e.cyc);
            chk("grant_dir", 32'(grant_dir_o), 32'(e.dir));
          end
          g = grant_o;
        end
      end
      @(posedge clk);
      if (!rst_n || clear_count_i) exp_cnt = '0;
      else if (g) exp_cnt = exp_cnt + 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  task automatic do_req(input logic [1:0] dir, input logic [N-1:0] u, input logic [N-1:0] d,
                        input logic [N-1:0] l, input logic [N-1:0] r,
                        input logic any, input bit clr_on_grant);
    bit           ok;
    bit           seen;
    int           a;
    int           exp_idle;
    logic         legal;
    logic [N-1:0] sel;
    wait_ready(ok);
    if (!ok) return;
    up_en_i = u; down_en_i = d; left_en_i = l; right_en_i = r;
    mode_any_i = any; req_dir_i = dir; req_valid_i = 1'b1; clear_count_i = 1'b0;
    case (dir)
      2'd0: sel = u;
      2'd1: sel = d;
      2'd2: sel = l;
      default: sel = r;
    endcase
    legal = legal_of(sel, any);
    @(negedge clk);
    a = cyc;
    req_valid_i = 1'b0;
    exp_q.push_back('{gnt: legal, dir: dir, cyc: 32'(a + 1)});
    chk("ready_in_check", 32'(req_ready_o), 32'd0);
    chk("busy_in_check", 32'(busy_o), 32'd1);
    // Inputs changing after acceptance must not alter the decision
    up_en_i = rand_vec(); down_en_i = rand_vec(); left_en_i = rand_vec(); right_en_i = rand_vec();
    mode_any_i = 1'($urandom_range(0, 1));
    exp_idle = legal ? a + 2 + LOCK : a + 2;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        seen = 1'b1;
        break;
      end
      chk("busy_while_not_ready", 32'(busy_o), 32'd1);
      req_valid_i = 1'($urandom_range(0, 1));
      req_dir_i = 2'($urandom);
      clear_count_i = (clr_on_grant && cyc == a + 1) || (rand_clr && $urandom_range(0, 15) == 0);
    end
    req_valid_i = 1'b0;
    clear_count_i = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy after 100 cycles expected idle at cycle %0d", exp_idle);
    end else begin
      chk("idle_cycle", 32'(cyc), 32'(exp_idle));
      chk("busy_when_ready", 32'(busy_o), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_grant"}, 32'(grant_o), 32'd0);
    chk({tag, "_deny"}, 32'(deny_o), 32'd0);
    chk({tag, "_en"}, 32'({up_en_o, down_en_o, left_en_o, right_en_o}), 32'd0);
    chk({tag, "_grant_dir"}, 32'(grant_dir_o), 32'd0);
    chk({tag, "_count"}, 32'(move_count_o), 32'd0);
  endtask

  task automatic reset_mid_lock();
    bit ok;
    int a;
    wait_ready(ok);
    if (!ok) return;
    up_en_i = '1; down_en_i = '1; left_en_i = '1; right_en_i = '1;
    mode_any_i = 1'b0; req_dir_i = 2'd3; req_valid_i = 1'b1;
    @(negedge clk);
    a = cyc;
    req_valid_i = 1'b0;
    exp_q.push_back('{gnt: 1'b1, dir: 2'd3, cyc: 32'(a + 1)});
    // LOCK occupies cycles a+2 .. a+1+LOCK; the fifth one is a+6
    for (int i = 0; i < 10 && cyc != a + 6; i++) @(negedge clk);
    chk("busy_in_lock5", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midlock_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midlock_rst", 32'(req_ready_o), 32'd1);
    chk("busy_after_midlock_rst", 32'(busy_o), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] v_up, v_dn, v_lf, v_rt;
    logic         any;
    up_en_i = '0; down_en_i = '0; left_en_i = '0; right_en_i = '0;
    mode_any_i = 1'b0; req_valid_i = 1'b0; req_dir_i = 2'd0; clear_count_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("init_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_init_rst", 32'(req_ready_o), 32'd1);

    // Every pattern of one direction in both modes; other directions random
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < (1 << N); p++) begin
        any = 1'(m);
        v_up = N'(p); v_dn = rand_vec(); v_lf = rand_vec(); v_rt = rand_vec();
        up_en_i = v_up; down_en_i = v_dn; left_en_i = v_lf; right_en_i = v_rt;
        mode_any_i = any;
        @(negedge clk);
        chk("up_en_o", 32'(up_en_o), 32'(legal_of(v_up, any)));
        chk("down_en_o", 32'(down_en_o), 32'(legal_of(v_dn, any)));
        chk("left_en_o", 32'(left_en_o), 32'(legal_of(v_lf, any)));
        chk("right_en_o", 32'(right_en_o), 32'(legal_of(v_rt, any)));
      end
    end

    do_req(2'd1, '1, '1, '1, '1, 1'b0, 1'b0);
    do_req(2'd2, '1, '1, 6'b011111, '1, 1'b0, 1'b0);
    do_req(2'd2, '1, '1, 6'b011111, '1, 1'b1, 1'b0);
    do_req(2'd0, '1, '1, '1, '1, 1'b0, 1'b1);
    repeat (17) do_req(2'($urandom), '1, '1, '1, '1, 1'b0, 1'b0);
    reset_mid_lock();

    rand_clr = 1'b1;
    repeat (40) do_req(2'($urandom), rand_vec(), rand_vec(), rand_vec(), rand_vec(),
                       1'($urandom_range(0, 1)), 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish within 400000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
